// File: rtl/branch_predictor.sv
// branch_predictor
//    Bimodal branch direction predictor: a table of BHT_ENTRIES 2-bit saturating
//    counters. Lookups answer one cycle later; resolves train the table.
//
//    Optional build macro: BRANCH_PRED_GSHARE_EN
//       defined   - table index is PC slice XOR a global history register (GHR)
//                   that shifts in each resolved outcome (non-speculative).
//       undefined - no GHR; table index is the PC slice only.
//
// Ports
//    clock          sole clock, rising edge
//    reset_n        asynchronous active-low reset
//    lookup_valid   prediction request
//    lookup_pc      PC of the branch to predict (bits [1:0] ignored)
//    pred_valid     registered response valid
//    pred_take      predicted direction, holds while pred_valid=0
//    pred_idx       table index used, holds while pred_valid=0
//    resolve_valid  branch resolved this cycle
//    resolve_idx    index returned from pred_idx
//    resolve_take   actual outcome
//    resolve_pred   direction that was predicted
//    mispredict     registered one-cycle pulse when resolve_take != resolve_pred

module branch_predictor #(
   parameter int BHT_ENTRIES = 64,
   parameter int IDX_BITS    = $clog2(BHT_ENTRIES),
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  lookup_valid,
   input  logic [ADDR_WIDTH-1:0] lookup_pc,
   output logic                  pred_valid,
   output logic                  pred_take,
   output logic [IDX_BITS-1:0]   pred_idx,
   input  logic                  resolve_valid,
   input  logic [IDX_BITS-1:0]   resolve_idx,
   input  logic                  resolve_take,
   input  logic                  resolve_pred,
   output logic                  mispredict
);

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_ST  = 2'b11;

   logic [1:0]          bht [BHT_ENTRIES];
   logic [IDX_BITS-1:0] lookup_idx;
   logic [1:0]          cur_ctr;
   logic [1:0]          next_ctr;

`ifdef BRANCH_PRED_GSHARE_EN
   logic [IDX_BITS-1:0] ghr;

   // History is updated only from resolved branches, so it never needs repair.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ghr <= '0;
      end else if (resolve_valid) begin
         ghr <= {ghr[IDX_BITS-2:0], resolve_take};
      end
   end

   assign lookup_idx = lookup_pc[IDX_BITS+1:2] ^ ghr;
`else
   assign lookup_idx = lookup_pc[IDX_BITS+1:2];
`endif

   assign cur_ctr = bht[resolve_idx];

   always_comb begin
      next_ctr = cur_ctr;
      if (resolve_take) begin
         if (cur_ctr != CTR_ST) next_ctr = cur_ctr + 2'b01;
      end else begin
         if (cur_ctr != CTR_SNT) next_ctr = cur_ctr - 2'b01;
      end
   end

   // A lookup to the entry being trained in the same cycle reads the old value,
   // since the table read is combinational from the pre-edge contents.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= CTR_WNT;
         end
      end else if (resolve_valid) begin
         bht[resolve_idx] <= next_ctr;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pred_valid <= 1'b0;
         pred_take  <= 1'b0;
         pred_idx   <= '0;
      end else begin
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            pred_take <= bht[lookup_idx][1];
            pred_idx  <= lookup_idx;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mispredict <= 1'b0;
      end else begin
         mispredict <= resolve_valid && (resolve_take != resolve_pred);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   localparam int BHT_ENTRIES = 64;
   localparam int IDX_BITS    = 6;
   localparam int ADDR_WIDTH  = 32;

   logic                  clock;
   logic                  reset_n;
   logic                  lookup_valid;
   logic [ADDR_WIDTH-1:0] lookup_pc;
   logic                  pred_valid;
   logic                  pred_take;
   logic [IDX_BITS-1:0]   pred_idx;
   logic                  resolve_valid;
   logic [IDX_BITS-1:0]   resolve_idx;
   logic                  resolve_take;
   logic                  resolve_pred;
   logic                  mispredict;

   int checks   = 0;
   int failures = 0;

   branch_predictor #(
      .BHT_ENTRIES(BHT_ENTRIES),
      .IDX_BITS   (IDX_BITS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .lookup_valid (lookup_valid),
      .lookup_pc    (lookup_pc),
      .pred_valid   (pred_valid),
      .pred_take    (pred_take),
      .pred_idx     (pred_idx),
      .resolve_valid(resolve_valid),
      .resolve_idx  (resolve_idx),
      .resolve_take (resolve_take),
      .resolve_pred (resolve_pred),
      .mispredict   (mispredict)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic resolve_n(input int n, input logic [IDX_BITS-1:0] idx, input logic take);
      for (int k = 0; k < n; k++) begin
         resolve_valid = 1'b1;
         resolve_idx   = idx;
         resolve_take  = take;
         resolve_pred  = take;
         cycle();
      end
      resolve_valid = 1'b0;
   endtask

   // Issues one lookup and checks the response the following cycle.
   task automatic lookup_check(input string name, input logic [ADDR_WIDTH-1:0] pc,
                               input logic exp_take, input logic [IDX_BITS-1:0] exp_idx);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      cycle();
      lookup_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b1 || pred_take !== exp_take || pred_idx !== exp_idx) begin
         failures++;
         $display("FAIL %s valid=%0b take=%0b idx=%0d expected valid=1 take=%0b idx=%0d",
                  name, pred_valid, pred_take, pred_idx, exp_take, exp_idx);
      end
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      lookup_valid  = 1'b0;
      lookup_pc     = '0;
      resolve_valid = 1'b0;
      resolve_idx   = '0;
      resolve_take  = 1'b0;
      resolve_pred  = 1'b0;
      cycle();
      cycle();
      checks++;
      if (pred_valid !== 1'b0 || pred_take !== 1'b0 || pred_idx !== '0 || mispredict !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs valid=%0b take=%0b idx=%0d misp=%0b expected all 0",
                  pred_valid, pred_take, pred_idx, mispredict);
      end
      reset_n = 1'b1;
      cycle();
   endtask

   task automatic test_first_lookup();
      lookup_check("first_lookup", 32'h100, 1'b0, 6'd0);
      cycle();
      checks++;
      if (pred_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_valid valid=%0b expected 0", pred_valid);
      end
   endtask

   task automatic test_saturate();
      resolve_n(3, 6'd5, 1'b1);                     // 01->10->11->11
      lookup_check("sat_top", 32'h14, 1'b1, 6'd5);
      cycle();
      checks++;
      if (pred_valid !== 1'b0 || pred_take !== 1'b1 || pred_idx !== 6'd5) begin
         failures++;
         $display("FAIL hold valid=%0b take=%0b idx=%0d expected valid=0 take=1 idx=5",
                  pred_valid, pred_take, pred_idx);
      end
      resolve_n(1, 6'd5, 1'b0);                     // 11->10
      lookup_check("sat_top_dec", 32'h14, 1'b1, 6'd5);
      resolve_n(3, 6'd5, 1'b0);                     // 10->01->00->00
      lookup_check("sat_bottom", 32'h14, 1'b0, 6'd5);
      resolve_n(1, 6'd5, 1'b1);                     // 00->01
      lookup_check("sat_bottom_inc1", 32'h14, 1'b0, 6'd5);
      resolve_n(1, 6'd5, 1'b1);                     // 01->10
      lookup_check("sat_bottom_inc2", 32'h17, 1'b1, 6'd5);
   endtask

   task automatic test_same_cycle();
      lookup_valid  = 1'b1;
      lookup_pc     = 32'h18;
      resolve_valid = 1'b1;
      resolve_idx   = 6'd6;
      resolve_take  = 1'b1;
      resolve_pred  = 1'b1;
      cycle();
      resolve_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b1 || pred_take !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_old valid=%0b take=%0b expected valid=1 take=0",
                  pred_valid, pred_take);
      end
      cycle();
      lookup_valid = 1'b0;
      checks++;
      if (pred_valid !== 1'b1 || pred_take !== 1'b1) begin
         failures++;
         $display("FAIL same_cycle_new valid=%0b take=%0b expected valid=1 take=1",
                  pred_valid, pred_take);
      end
   endtask

   task automatic test_mispredict();
      // {valid, take, pred, expected mispredict}; entry 7 ends 01->10->11->10
      logic [3:0] vec [6];
      vec[0] = 4'b1101;
      vec[1] = 4'b0000;
      vec[2] = 4'b1110;
      vec[3] = 4'b1011;
      vec[4] = 4'b0000;
      vec[5] = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         resolve_valid = vec[i][3];
         resolve_idx   = 6'd7;
         resolve_take  = vec[i][2];
         resolve_pred  = vec[i][1];
         cycle();
         checks++;
         if (mispredict !== vec[i][0]) begin
            failures++;
            $display("FAIL mispredict_%0d misp=%0b expected %0b", i, mispredict, vec[i][0]);
         end
      end
      resolve_valid = 1'b0;
      resolve_take  = 1'b0;
      resolve_pred  = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp_take;
      exp_take = 10'b00_1110_0000;                 // entries 5,6,7 taken
      for (int i = 0; i < 10; i++) begin
         lookup_valid = 1'b1;
         lookup_pc    = 32'(i * 4);
         cycle();
         checks++;
         if (pred_valid !== 1'b1 || pred_idx !== 6'(i) || pred_take !== exp_take[i]) begin
            failures++;
            $display("FAIL b2b_%0d valid=%0b idx=%0d take=%0b expected valid=1 idx=%0d take=%0b",
                     i, pred_valid, pred_idx, pred_take, i, exp_take[i]);
         end
      end
      // Lookup still in flight; a resolve is pending when reset hits.
      lookup_pc     = 32'h14;
      resolve_valid = 1'b1;
      resolve_idx   = 6'd6;
      resolve_take  = 1'b1;
      resolve_pred  = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (pred_valid !== 1'b0 || pred_idx !== '0 || pred_take !== 1'b0) begin
         failures++;
         $display("FAIL reset_async valid=%0b idx=%0d take=%0b expected all 0",
                  pred_valid, pred_idx, pred_take);
      end
      cycle();
      checks++;
      if (pred_valid !== 1'b0 || mispredict !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold valid=%0b misp=%0b expected 0 0", pred_valid, mispredict);
      end
      lookup_valid  = 1'b0;
      resolve_valid = 1'b0;
      reset_n       = 1'b1;
      cycle();
      checks++;
      if (pred_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_drop valid=%0b expected 0", pred_valid);
      end
      lookup_check("post_reset_5", 32'h14, 1'b0, 6'd5);
      lookup_check("post_reset_6", 32'h18, 1'b0, 6'd6);
      lookup_check("post_reset_7", 32'h1C, 1'b0, 6'd7);
   endtask

`ifdef BRANCH_PRED_GSHARE_EN
   task automatic test_gshare();
      resolve_n(1, 6'd0, 1'b1);                     // GHR=000001, entry 0 -> 10
      lookup_check("gshare_pc0", 32'h0, 1'b0, 6'd1);
      lookup_check("gshare_pc4", 32'h4, 1'b1, 6'd0);
   endtask
`endif

   initial begin
      test_reset();
`ifdef BRANCH_PRED_GSHARE_EN
      test_gshare();
`else
      test_first_lookup();
      test_saturate();
      test_same_cycle();
      test_mispredict();
      test_back_to_back();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 64, number of 2-bit counters; power of two, at least 4.
REQ-002 SHALL have parameter IDX_BITS, default $clog2(BHT_ENTRIES), index width and GHR width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clock  input  1  sole clock, all state rising-edge; reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port lookup_valid  input  1  prediction request.
REQ-005 SHALL have port lookup_pc  input  ADDR  PC of the branch to predict.
REQ-006 SHALL have port pred_valid  output  1  registered response valid.
REQ-007 SHALL have port pred_take  output  1  predicted direction, qualified by pred_valid.
REQ-008 SHALL have port pred_idx  output  IDX_BITS  table index used; travels with the branch.
REQ-009 SHALL have port resolve_valid  input  1  branch resolved by the conditional branch unit.
REQ-010 SHALL have port resolve_idx  input  IDX_BITS  index returned from pred_idx.
REQ-011 SHALL have port resolve_take  input  1  actual outcome (the resolver's take).
REQ-012 SHALL have port resolve_pred  input  1  direction that was predicted.
REQ-013 SHALL have port mispredict  output  1  registered one-cycle pulse, resolve_take != resolve_pred.

Function
REQ-014 Each entry SHALL be a 2-bit saturating counter with states SNT=00, WNT=01, WT=10, ST=11; predict taken iff bit 1 is set.
REQ-015 Index SHALL be lookup_pc[IDX_BITS+1:2]; PC bits [1:0] are ignored.
REQ-016 Lookup latency SHALL be one cycle: request in cycle N gives pred_valid=1 with pred_take/pred_idx in cycle N+1; pred_valid=0 when no request; back-to-back requests every cycle are supported.
REQ-017 On resolve_valid, entry resolve_idx SHALL increment if resolve_take=1, else decrement, saturating at 11 and 00 (no wrap).
REQ-018 mispredict SHALL assert in the cycle after resolve_valid when resolve_take != resolve_pred; otherwise 0.
REQ-019 Lookup and resolve to the same index in the same cycle SHALL return the pre-update counter value; the update lands at the same edge.
REQ-020 At most one resolve per cycle; resolve_idx out of range cannot occur when IDX_BITS = log2(BHT_ENTRIES).
REQ-021 pred_take/pred_idx SHALL hold their last values while pred_valid=0.

Reset
REQ-022 While reset_n=0, all counters SHALL be WNT (01), GHR 0, and pred_valid, pred_take, pred_idx and mispredict SHALL be 0.
REQ-023 Reset SHALL act asynchronously; a lookup in flight when reset asserts is dropped, with no pred_valid afterwards.
REQ-024 A resolve coincident with reset assertion SHALL NOT modify the table.

Configuration
REQ-025 Macro BRANCH_PRED_GSHARE_EN defined: index = lookup_pc[IDX_BITS+1:2] XOR GHR; GHR (IDX_BITS wide) shifts in resolve_take at LSB on every resolve_valid (non-speculative); pred_idx reports the XORed index.
REQ-026 BRANCH_PRED_GSHARE_EN undefined: no GHR register exists; index is the PC slice only (REQ-015).

Verification
REQ-027 After reset, lookup pc=0x100 -> next cycle pred_valid=1, pred_take=0, pred_idx=0 (0x100[7:2]=0).
REQ-028 Three resolves idx=5 take=1, then lookup pc=0x14 -> pred_take=1; four resolves take=0 then lookup -> pred_take=0 (counter saturates ST, then reaches SNT with no wrap).
REQ-029 Same cycle: lookup pc=0x14 and resolve idx=5 take=1, from WNT -> pred_take=0; lookup next cycle -> pred_take=1.
REQ-030 resolve take=1 pred=0 -> mispredict=1 for exactly one cycle; take=1 pred=1 -> mispredict stays 0.
REQ-031 Lookup every cycle for 10 cycles, then assert reset_n=0 mid-stream -> pred_valid=0 immediately and counters back to WNT.
REQ-032 With BRANCH_PRED_GSHARE_EN: resolve take=1 once (GHR=000001), lookup pc=0x0 -> pred_idx=1.
